// File: rtl/gray_pkg.sv
// Shared Gray-code constants and conversion helpers.
// Functions operate on a 32-bit word; narrower values are zero-extended by the caller.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH_DEFAULT = 8;
    localparam int unsigned GRAY_WIDTH_MIN     = 2;
    localparam int unsigned GRAY_WIDTH_MAX     = 32;

    typedef logic [GRAY_WIDTH_MAX-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
        for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Output bus of the Gray counter; the counter drives it through the master modport.
interface gray_counter_if
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] gray;

    modport master (output gray);
    modport slave  (input  gray);

endinterface

// File: rtl/gray_bin2gray.sv
// Purely combinational binary-to-Gray converter.
module gray_bin2gray #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Free-running Gray-code counter: binary count register plus a registered Gray output,
// so the output comes straight from flops and changes exactly one bit per clock.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_counter_if.master out_if
);

    if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_width_check
        $error("gray_counter: WIDTH must be in 2..32");
    end

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    // Wraps modulo 2^WIDTH; no overflow flag.
    always_comb begin
        bin_d = bin_q + WIDTH'(1);
    end

    // Convert the next count so the Gray register lands in step with bin_q.
    gray_bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign out_if.gray = gray_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH=8 and WIDTH=4 sharing one clock and reset.
module tb_gray_counter;
    import gray_pkg::*;

    logic clk;
    logic rst_n;

    gray_counter_if #(.WIDTH(8)) if8 ();
    gray_counter_if #(.WIDTH(4)) if4 ();

    gray_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .out_if(if8.master));
    gray_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .out_if(if4.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] m8;
    logic [3:0] m4;
    logic [7:0] q8[$];
    logic [3:0] q4[$];

    typedef struct {
        logic [7:0] g8;
        logic [3:0] g4;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: push the model's expectation, then pop and compare after the edge.
    task automatic edge_step(input string name);
        logic [7:0] n8;
        logic [3:0] n4;
        @(posedge clk);
        n8 = m8 + 8'd1;
        n4 = m4 + 4'd1;
        q8.push_back(n8 ^ (n8 >> 1));
        q4.push_back(n4 ^ (n4 >> 1));
        m8 = n8;
        m4 = n4;
        #1;
        chk({name, "_w8"}, 32'(if8.gray), 32'(q8.pop_front()));
        chk({name, "_w4"}, 32'(if4.gray), 32'(q4.pop_front()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_w8", 32'(if8.gray), 32'h0);
        chk("reset_w4", 32'(if4.gray), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m8 = '0;
        m4 = '0;
        q8.delete();
        q4.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prev8;
        logic [3:0] prev4;
        int period;

        tbl[0]  = '{8'h01, 4'h1}; tbl[1]  = '{8'h03, 4'h3};
        tbl[2]  = '{8'h02, 4'h2}; tbl[3]  = '{8'h06, 4'h6};
        tbl[4]  = '{8'h07, 4'h7}; tbl[5]  = '{8'h05, 4'h5};
        tbl[6]  = '{8'h04, 4'h4}; tbl[7]  = '{8'h0C, 4'hC};
        tbl[8]  = '{8'h0D, 4'hD}; tbl[9]  = '{8'h0F, 4'hF};
        tbl[10] = '{8'h0E, 4'hE}; tbl[11] = '{8'h0A, 4'hA};
        tbl[12] = '{8'h0B, 4'hB}; tbl[13] = '{8'h09, 4'h9};
        tbl[14] = '{8'h08, 4'h8}; tbl[15] = '{8'h18, 4'h0};
        tbl[16] = '{8'h19, 4'h1}; tbl[17] = '{8'h1B, 4'h3};
        tbl[18] = '{8'h1A, 4'h2}; tbl[19] = '{8'h1E, 4'h6};

        // Reset hold across two clock edges, release at t=20.
        rst_n = 1'b0;
        m8 = '0;
        m4 = '0;
        #7;
        chk("hold_t7_w8", 32'(if8.gray), 32'h0);
        chk("hold_t7_w4", 32'(if4.gray), 32'h0);
        #10;
        chk("hold_t17_w8", 32'(if8.gray), 32'h0);
        chk("hold_t17_w4", 32'(if4.gray), 32'h0);
        #3;
        rst_n = 1'b1;

        // Table-driven first 20 edges, with gray2bin tracking the count.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            q8.push_back(tbl[i].g8);
            q4.push_back(tbl[i].g4);
            m8 = m8 + 8'd1;
            m4 = m4 + 4'd1;
            #1;
            chk($sformatf("seq%0d_w8", i + 1), 32'(if8.gray), 32'(q8.pop_front()));
            chk($sformatf("seq%0d_w4", i + 1), 32'(if4.gray), 32'(q4.pop_front()));
            chk($sformatf("g2b%0d", i + 1), gray2bin(32'(if8.gray)), 32'(i + 1));
        end

        // Single-bit-change property over 600 edges, crossing several wraps.
        for (int i = 0; i < 600; i++) begin
            prev8 = if8.gray;
            prev4 = if4.gray;
            edge_step("run");
            chk("onehot_w8", 32'($countones(prev8 ^ if8.gray)), 32'd1);
            chk("onehot_w4", 32'($countones(prev4 ^ if4.gray)), 32'd1);
        end

        // Wrap at WIDTH=8 and period measurement.
        do_reset();
        repeat (255) edge_step("pre_wrap");
        chk("wrap_last_w8", 32'(if8.gray), 32'h80);
        chk("wrap_last_w4", 32'(if4.gray), 32'h8);
        edge_step("wrap");
        chk("wrap_zero_w8", 32'(if8.gray), 32'h00);
        edge_step("post_wrap");
        chk("wrap_one_w8", 32'(if8.gray), 32'h01);
        period = 0;
        for (int n = 1; n <= 300; n++) begin
            edge_step("period");
            if (if8.gray == 8'h01) begin
                period = n;
                break;
            end
        end
        chk("period_w8", 32'(period), 32'd256);

        // Asynchronous reset pulse between edges mid-count.
        do_reset();
        repeat (37) edge_step("mid");
        chk("mid37_w8", 32'(if8.gray), 32'h37);
        chk("mid37_w4", 32'(if4.gray), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clr_w8", 32'(if8.gray), 32'h0);
        chk("async_clr_w4", 32'(if4.gray), 32'h0);
        #2;
        rst_n = 1'b1;
        m8 = '0;
        m4 = '0;
        edge_step("after_async");
        chk("after_async_w8", 32'(if8.gray), 32'h01);
        chk("after_async_w4", 32'(if4.gray), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
